// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control unit: exception codes,
// stall encodings, default exception vector and controller state type.
package mips_defs;

  // Exception codes delivered by the MEM stage (0 means no exception).
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000A;
  localparam logic [31:0] EXC_OV      = 32'h0000_000C;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

  // Stall vectors: bit0 = PC, bits1..5 = if_id, id_ex, ex_mem, mem_wb, WB hold.
  // A stage requesting a stall freezes itself and everything upstream.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } ctrl_state_e;

  // Fixed-priority stall arbitration: the furthest-downstream request wins
  // because its vector covers every upstream stage as well.
  function automatic logic [5:0] encode_stall(input logic req_if,
                                              input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Stuck-stall watchdog: counts consecutive stalled cycles, saturates at
// MAX_STALL and raises a sticky timeout flag once the limit is reached.
module stall_watchdog #(
  parameter int unsigned MAX_STALL = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  input  logic clear,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] SAT = CW'(MAX_STALL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Next-state for the consecutive counter and the sticky flag.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !stalled) begin
      cnt_d = '0;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + CW'(1);
    end
    // The flag rises on the edge that ends the MAX_STALL-th stalled cycle.
    timeout_d = timeout_q | (cnt_d == SAT);
  end

  // Counter and flag registers, cleared only by reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: arbitrates per-stage stall requests, turns a MEM
// exception into a one-cycle flush plus redirect PC, counts stalled cycles
// and watches for a pipeline stuck in stall.
module pipeline_ctrl
  import mips_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned MAX_STALL  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  ctrl_state_e state_q, state_d;
  logic [31:0] stall_cycles_q;
  logic        exc_taken;

  // An exception is only honoured in RUN; in REDIRECT the code is stale
  // because it belongs to the slot that was just flushed.
  assign exc_taken = !rst && (state_q == ST_RUN) && (excepttype_i != EXC_NONE);

  // Zero-latency control outputs; flush overrides any stall request.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      stall  = STALL_NONE;
    end else if (exc_taken) begin
      flush  = 1'b1;
      new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end else begin
      stall  = encode_stall(stallreq_from_if, stallreq_from_id,
                            stallreq_from_ex, stallreq_from_mem);
    end
  end

  // REDIRECT always lasts exactly one cycle.
  always_comb begin
    state_d = exc_taken ? ST_REDIRECT : ST_RUN;
  end

  // FSM and stall performance counter (wraps naturally at 2^32).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (stall[0]) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stalled (stall[0]),
    .clear   (flush),
    .timeout (stall_timeout)
  );

  assign stall_cycles = stall_cycles_q;

endmodule
